// File: rtl/text_writer_pkg.sv
// text_writer_pkg: shared screen geometry, character codes and writer states
package text_writer_pkg;
  localparam int COLS_DEF = 70;
  localparam int ROWS_DEF = 30;
  localparam int CELLS = COLS_DEF * ROWS_DEF;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRITE, CLEAR_ROW} state_t;
endpackage

// File: rtl/text_cursor.sv
// text_cursor: row/col cursor with a running row base so the linear index needs no multiplier
module text_cursor
  import text_writer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adv,
  input  logic        nl,
  input  logic        bs,
  output logic        col_last,
  output logic        col_zero,
  output logic [11:0] idx
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [11:0] base;
  logic wrap, row_last;
  assign col_last = col == CW'(COLS - 1);
  assign col_zero = col == '0;
  assign row_last = row == RW'(ROWS - 1);
  assign wrap = nl || (adv && col_last);
  assign idx = base + 12'(col);
  always_ff @(posedge clk)
    if (!reset_n) begin
      col <= '0;
      row <= '0;
      base <= '0;
    end else if (wrap) begin
      col <= '0;
      row <= row_last ? '0 : row + 1'b1;
      base <= row_last ? '0 : base + 12'(COLS);
    end else if (adv) col <= col + 1'b1;
    else if (bs && !col_zero) col <= col - 1'b1;
endmodule

// File: rtl/text_writer.sv
// text_writer: turns an ASCII stream into character-RAM writes with screen and row clearing
module text_writer
  import text_writer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ascii_valid,
  input  logic [7:0]  ascii,
  output logic        ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] cursor
);
  localparam int NC = COLS * ROWS;
  state_t state;
  logic [11:0] cnt;
  logic take, printable, adv, nl, bs_go, col_last, col_zero;
  assign ready = state == IDLE;
  assign take = ready && ascii_valid;
  assign printable = ascii >= 8'h20 && ascii <= 8'h7E;
  assign adv = take && printable;
  assign nl = take && ascii == LF;
  assign bs_go = take && ascii == BS && !col_zero;
  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk(clk),
    .reset_n(reset_n),
    .adv(adv),
    .nl(nl),
    .bs(bs_go),
    .col_last(col_last),
    .col_zero(col_zero),
    .idx(cursor)
  );
  // Clears run one extra cycle past the last write so ready rises only after it
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= CLEAR_ALL;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        CLEAR_ALL, CLEAR_ROW:
          if (cnt == (state == CLEAR_ALL ? 12'(NC) : 12'(COLS))) state <= IDLE;
          else begin
            wr_en <= 1'b1;
            wr_addr <= state == CLEAR_ALL ? cnt : cursor + cnt;
            wr_data <= SPACE;
            cnt <= cnt + 1'b1;
          end
        IDLE:
          if (ascii_valid) begin
            state <= ((adv && col_last) || nl) ? CLEAR_ROW : WRITE;
            cnt <= '0;
            wr_en <= adv || bs_go;
            wr_addr <= bs_go ? cursor - 12'd1 : cursor;
            wr_data <= bs_go ? SPACE : ascii;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: randomized checks of text_writer against a screen-level cursor model
module tb_text_writer;
  localparam int COLS = 70, ROWS = 30, NC = COLS * ROWS;
  logic clk = 0, reset_n = 0, ascii_valid = 0, ready, wr_en;
  logic [7:0] ascii = 0, wr_data;
  logic [11:0] wr_addr, cursor;
  int checks = 0, errors = 0, mrow = 0, mcol = 0;
  logic [19:0] wq[$], eq[$];

  text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n), .ascii_valid(ascii_valid), .ascii(ascii),
    .ready(ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cursor(cursor)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en) wq.push_back({wr_addr, wr_data});
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int model_step(input logic [7:0] c);
    int busy = 1;
    bit nl = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      eq.push_back({12'(mrow * COLS + mcol), c});
      mcol++;
      nl = mcol == COLS;
    end else if (c == 8'h0A) nl = 1;
    else if (c == 8'h08 && mcol > 0) begin
      mcol--;
      eq.push_back({12'(mrow * COLS + mcol), 8'h20});
    end
    if (nl) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      for (int i = 0; i < COLS; i++) eq.push_back({12'(mrow * COLS + i), 8'h20});
      busy = COLS + 1;
    end
    return busy;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_ready: ready=%b required 1", tag, ready);
    end
  endtask

  task automatic send(input logic [7:0] c, input string tag);
    int busy, n, bad;
    wait_ready(tag);
    eq.delete();
    busy = model_step(c);
    wq.delete();
    ascii = c;
    ascii_valid = 1;
    @(negedge clk);
    ascii_valid = 0;
    ascii = 8'($urandom);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != busy) begin
      errors++;
      $display("FAIL %s busy: got %0d cycles required %0d", tag, n, busy);
    end
    bad = 0;
    for (int i = 0; i < wq.size() && i < eq.size(); i++) if (wq[i] !== eq[i]) bad++;
    checks++;
    if (wq.size() != eq.size() || bad != 0) begin
      errors++;
      $display("FAIL %s writes: got %0d writes (%0d wrong) required %0d, first got %h required %h",
               tag, wq.size(), bad, eq.size(), wq.size() ? wq[0] : 20'h0, eq.size() ? eq[0] : 20'h0);
    end
    checks++;
    if (cursor !== 12'(mrow * COLS + mcol)) begin
      errors++;
      $display("FAIL %s cursor: got %0d required %0d", tag, cursor, mrow * COLS + mcol);
    end
  endtask

  task automatic check_clear_all(input string tag);
    int k = 0, bad = 0, n = 0;
    bit last_wr = 0;
    reset_n = 1;
    @(negedge clk);
    while (!ready && n < NC + 50) begin
      if (wr_en) begin
        if (wr_addr !== 12'(k) || wr_data !== 8'h20) bad++;
        k++;
      end
      last_wr = wr_en;
      n++;
      @(negedge clk);
    end
    checks++;
    if (k != NC || bad != 0) begin
      errors++;
      $display("FAIL %s clear_writes: got %0d writes (%0d wrong) required %0d", tag, k, bad, NC);
    end
    checks++;
    if (n != NC) begin
      errors++;
      $display("FAIL %s clear_cycles: got %0d busy cycles required %0d", tag, n, NC);
    end
    checks++;
    if (ready !== 1'b1 || !last_wr || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_rise: ready=%b last_wr=%b wr_en=%b required 1 1 0", tag, ready, last_wr, wr_en);
    end
    checks++;
    if (cursor !== 12'd0) begin
      errors++;
      $display("FAIL %s clear_cursor: got %0d required 0", tag, cursor);
    end
    mrow = 0;
    mcol = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    ascii_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || ready !== 1'b0 || cursor !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: wr_en=%b ready=%b cursor=%0d required 0 0 0", wr_en, ready, cursor);
    end
    check_clear_all("reset");
  endtask

  task automatic test_chars;
    send(8'h61, "char_a");
    send(8'h62, "char_b");
  endtask

  task automatic test_wrap;
    while (mcol != COLS - 1) send(8'($urandom_range(32, 126)), "fill");
    send(8'h41, "wrap_A");
  endtask

  task automatic test_backspace;
    send(8'($urandom_range(32, 126)), "bs_setup");
    send(8'h08, "bs_first");
    send(8'h08, "bs_col0");
    send(8'h07, "bell");
  endtask

  task automatic test_newline_wrap;
    while (mrow != ROWS - 1) send(8'h0A, "nl_step");
    while (mcol != 19) send(8'($urandom_range(32, 126)), "nl_fill");
    send(8'h0A, "nl_bottom");
  endtask

  task automatic test_random;
    logic [7:0] c;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        6: c = 8'h0A;
        7, 8: c = 8'h08;
        9: c = $urandom_range(0, 1) ? 8'($urandom_range(128, 255)) : 8'h7F;
        default: c = 8'($urandom_range(32, 126));
      endcase
      send(c, "random");
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    wait_ready("mid");
    ascii = 8'h0A;
    ascii_valid = 1;
    @(negedge clk);
    ascii = 8'h5A;
    for (int i = 0; i < 30; i++) begin
      if (ready !== 1'b0 || (wr_en && wr_data !== 8'h20)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_busy: %0d cycles accepted or wrote non-space, required 0", bad);
    end
    reset_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || ready !== 1'b0 || cursor !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset: wr_en=%b ready=%b cursor=%0d required 0 0 0", wr_en, ready, cursor);
    end
    check_clear_all("mid");
    ascii_valid = 0;
    send(8'h78, "after_reset");
  endtask

  initial begin
    test_reset;
    test_chars;
    test_wrap;
    test_backspace;
    test_newline_wrap;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
